// File: rtl/calc_entry_core.sv
// calc_entry_core: collects two BCD operands of up to NUM_DIGITS digits,
// converts them to binary, adds (or subtracts), and converts the result back
// to BCD with shift-add-3 for a blank-suppressed display.
// Optional feature macro: CALC_SUB_EN enables op 01 (subtract, |A-B| with sign).
module calc_entry_core #(
  parameter int NUM_DIGITS = 2
) (
  input  logic                        i_Clk,
  input  logic                        i_Reset,
  input  logic                        i_Digit_Valid,
  input  logic [3:0]                  i_Digit,
  input  logic                        i_Op_Valid,
  input  logic [1:0]                  i_Op,
  input  logic                        i_Equals,
  input  logic                        i_Clear,
  output logic [4*(NUM_DIGITS+1)-1:0] o_Display,
  output logic                        o_Negative,
  output logic [1:0]                  o_Op_Sel,
  output logic [2:0]                  o_State,
  output logic                        o_Busy,
  output logic                        o_Done
);

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam int DISP_DIGITS = NUM_DIGITS + 1;
  localparam int DISP_W      = 4 * DISP_DIGITS;
  localparam int OPD_W       = 4 * NUM_DIGITS;
  localparam int RES_W       = $clog2(2 * pow10(NUM_DIGITS));
  localparam int CNT_W       = $clog2(RES_W + 2);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_OPA      = 3'd1,
    S_OPB_WAIT = 3'd2,
    S_OPB      = 3'd3,
    S_CONV     = 3'd4,
    S_ALU      = 3'd5,
    S_B2D      = 3'd6,
    S_SHOW     = 3'd7
  } state_t;

  // Right-aligned operand with unused nibbles blanked.
  function automatic logic [DISP_W-1:0] entry_disp(input logic [OPD_W-1:0] v,
                                                   input logic [2:0] n);
    logic [DISP_W-1:0] d;
    d = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (i < int'(n)) d[4*i +: 4] = v[4*i +: 4];
    return d;
  endfunction

  // Blank leading zeros; the LS nibble is always shown.
  function automatic logic [DISP_W-1:0] blank_lz(input logic [DISP_W-1:0] v);
    logic [DISP_W-1:0] d;
    logic lead;
    d    = v;
    lead = 1'b1;
    for (int i = DISP_DIGITS - 1; i > 0; i--) begin
      if (lead && (v[4*i +: 4] == 4'd0)) d[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
    return d;
  endfunction

  // Shift-add-3 correction applied before each left shift.
  function automatic logic [DISP_W-1:0] add3(input logic [DISP_W-1:0] v);
    logic [DISP_W-1:0] r;
    r = v;
    for (int i = 0; i < DISP_DIGITS; i++)
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    return r;
  endfunction

  state_t              state_q;
  logic [OPD_W-1:0]    a_q, b_q;
  logic [2:0]          a_cnt_q, b_cnt_q;
  logic [1:0]          op_sel_q;
  logic [DISP_W-1:0]   disp_q;
  logic                busy_q, done_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [RES_W-1:0]    acc_a_q, acc_b_q, bin_q;
  logic [DISP_W-1:0]   bcd_q;

  logic                ev_eq, ev_op, ev_dig, dig_ok, dig_nz, op_ok, a_room, b_room;
  logic                load_res;
  logic [OPD_W-1:0]    dig_opd, a_app_d, b_app_d;
  logic [RES_W-1:0]    acc_a_d, acc_b_d, res_d, bin_shift_d;
  logic [DISP_W-1:0]   bcd_adj, bcd_shift_d;

  // Only the highest-priority event of a cycle survives.
  assign ev_eq  = i_Equals & ~i_Clear;
  assign ev_op  = i_Op_Valid & ~i_Equals & ~i_Clear;
  assign ev_dig = i_Digit_Valid & ~i_Op_Valid & ~i_Equals & ~i_Clear;
  assign dig_ok = (i_Digit <= 4'd9);
  assign dig_nz = dig_ok && (i_Digit != 4'd0);

`ifdef CALC_SUB_EN
  assign op_ok = (i_Op == 2'b00) || (i_Op == 2'b01);
`else
  assign op_ok = (i_Op == 2'b00);
`endif

  assign a_room  = (a_cnt_q < 3'(NUM_DIGITS));
  assign b_room  = (b_cnt_q < 3'(NUM_DIGITS));
  assign dig_opd = OPD_W'(i_Digit);
  assign a_app_d = (a_q << 4) | dig_opd;
  assign b_app_d = (b_q << 4) | dig_opd;

  // Operands are consumed MS digit first by shifting them out of the top.
  assign acc_a_d = acc_a_q * RES_W'(10) + RES_W'(a_q[OPD_W-1 -: 4]);
  assign acc_b_d = acc_b_q * RES_W'(10) + RES_W'(b_q[OPD_W-1 -: 4]);

  assign bcd_adj     = add3(bcd_q);
  assign bcd_shift_d = {bcd_adj[DISP_W-2:0], bin_q[RES_W-1]};
  assign bin_shift_d = {bin_q[RES_W-2:0], 1'b0};
  assign load_res    = (state_q == S_B2D) && (cnt_q == CNT_W'(RES_W));

`ifdef CALC_SUB_EN
  logic a_lt_b;
  assign a_lt_b = (acc_a_q < acc_b_q);

  // ALU result: sum, or magnitude of the difference for subtract.
  always_comb begin
    // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
    res_d = acc_a_q + acc_b_q;
    if (op_sel_q == 2'b01) res_d = a_lt_b ? (acc_b_q - acc_a_q) : (acc_a_q - acc_b_q);
  end
`else
  assign res_d = acc_a_q + acc_b_q;
`endif

  // Control FSM with operand, datapath and registered output updates.
  always_ff @(posedge i_Clk) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values.
    done_q <= 1'b0;
    if (i_Reset || i_Clear) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      a_cnt_q  <= '0;
      b_cnt_q  <= '0;
      op_sel_q <= 2'b00;
      disp_q   <= '1;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_a_q  <= '0;
      acc_b_q  <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_SHOW: begin
          if (ev_dig && dig_nz) begin
            a_q      <= dig_opd;
            a_cnt_q  <= 3'd1;
            b_q      <= '0;
            b_cnt_q  <= '0;
            op_sel_q <= 2'b00;
            disp_q   <= entry_disp(dig_opd, 3'd1);
            state_q  <= S_OPA;
          end
        end
        S_OPA: begin
          if (ev_op && op_ok) begin
            op_sel_q <= i_Op;
            disp_q   <= '1;
            state_q  <= S_OPB_WAIT;
          end else if (ev_dig && dig_ok && a_room) begin
            a_q     <= a_app_d;
            a_cnt_q <= a_cnt_q + 3'd1;
            disp_q  <= entry_disp(a_app_d, a_cnt_q + 3'd1);
          end
        end
        S_OPB_WAIT: begin
          if (ev_op && op_ok) begin
            op_sel_q <= i_Op;
          end else if (ev_dig && dig_nz) begin
            b_q     <= dig_opd;
            b_cnt_q <= 3'd1;
            disp_q  <= entry_disp(dig_opd, 3'd1);
            state_q <= S_OPB;
          end
        end
        S_OPB: begin
          if (ev_eq) begin
            acc_a_q <= '0;
            acc_b_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CONV;
          end else if (ev_dig && dig_ok && b_room) begin
            b_q     <= b_app_d;
            b_cnt_q <= b_cnt_q + 3'd1;
            disp_q  <= entry_disp(b_app_d, b_cnt_q + 3'd1);
          end
        end
        S_CONV: begin
          acc_a_q <= acc_a_d;
          acc_b_q <= acc_b_d;
          a_q     <= a_q << 4;
          b_q     <= b_q << 4;
          if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
            cnt_q   <= '0;
            state_q <= S_ALU;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_ALU: begin
          bin_q   <= res_d;
          bcd_q   <= '0;
          cnt_q   <= '0;
          state_q <= S_B2D;
        end
        S_B2D: begin
          if (load_res) begin
            disp_q  <= blank_lz(bcd_q);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_SHOW;
          end else begin
            bcd_q <= bcd_shift_d;
            bin_q <= bin_shift_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CALC_SUB_EN
  logic neg_q;
  logic restart;
  assign restart = (state_q == S_SHOW) && ev_dig && dig_nz;

  // Sign flag: captured with the result, dropped on clear or a fresh entry.
  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Clear || restart) neg_q <= 1'b0;
    else if (load_res)                 neg_q <= (op_sel_q == 2'b01) && a_lt_b;
  end
  assign o_Negative = neg_q;
`else
  assign o_Negative = 1'b0;
`endif

  assign o_Display = disp_q;
  assign o_Op_Sel  = op_sel_q;
  assign o_State   = state_q;
  assign o_Busy    = busy_q;
  assign o_Done    = done_q;

endmodule

// File: tb/tb_calc_entry_core.sv
// Testbench for calc_entry_core (NUM_DIGITS=2): keypress-level reference model,
// result scoreboard checked by a monitor on o_Done, plus per-cycle output checks.
module tb_calc_entry_core;

  localparam int N     = 2;
  localparam int DISP  = N + 1;
  localparam int DW    = 4 * DISP;
  localparam int RES_W = 8;
  localparam int L     = N + RES_W + 2;

  logic          clk = 1'b0;
  logic          i_Reset = 1'b0, i_Digit_Valid = 1'b0, i_Op_Valid = 1'b0;
  logic          i_Equals = 1'b0, i_Clear = 1'b0;
  logic [3:0]    i_Digit = 4'd0;
  logic [1:0]    i_Op = 2'd0;
  logic [DW-1:0] o_Display;
  logic          o_Negative, o_Busy, o_Done;
  logic [1:0]    o_Op_Sel;
  logic [2:0]    o_State;

  calc_entry_core #(.NUM_DIGITS(N)) dut (
    .i_Clk(clk), .i_Reset(i_Reset), .i_Digit_Valid(i_Digit_Valid), .i_Digit(i_Digit),
    .i_Op_Valid(i_Op_Valid), .i_Op(i_Op), .i_Equals(i_Equals), .i_Clear(i_Clear),
    .o_Display(o_Display), .o_Negative(o_Negative), .o_Op_Sel(o_Op_Sel),
    .o_State(o_State), .o_Busy(o_Busy), .o_Done(o_Done)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (keypress level) ----------------
  typedef enum {M_IDLE, M_OPA, M_WAIT, M_OPB, M_BUSY, M_SHOW} mode_t;
  typedef struct { logic [DW-1:0] disp; logic neg; int cyc; } exp_t;

  mode_t         mode;
  int            a_val, a_len, b_val, b_len, m_sel, busy_e;
  logic          m_neg;
  logic [DW-1:0] m_disp, pend_disp;
  logic          pend_neg;
  exp_t          exp_q[$];

  function automatic logic [DW-1:0] fmt_entry(input int val, input int len);
    logic [DW-1:0] d;
    int v;
    d = '1;
    v = val;
    for (int i = 0; i < DISP; i++) begin
      if (i < len) d[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return d;
  endfunction

  function automatic logic [DW-1:0] fmt_result(input int r);
    logic [DW-1:0] d;
    int v;
    d = '1;
    v = r;
    for (int i = 0; i < DISP; i++) begin
      if (i == 0 || v != 0) d[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return d;
  endfunction

  function automatic logic [2:0] exp_state();
    case (mode)
      M_IDLE:  return 3'd0;
      M_OPA:   return 3'd1;
      M_WAIT:  return 3'd2;
      M_OPB:   return 3'd3;
      M_SHOW:  return 3'd7;
      default: return (busy_e < N) ? 3'd4 : ((busy_e == N) ? 3'd5 : 3'd6);
    endcase
  endfunction

  task automatic model_clear();
    if (mode == M_BUSY && exp_q.size() > 0) void'(exp_q.pop_back());
    mode = M_IDLE; a_val = 0; a_len = 0; b_val = 0; b_len = 0;
    m_sel = 0; m_neg = 1'b0; m_disp = '1; busy_e = 0;
  endtask

  task automatic model_step(input bit dv, input int d, input bit ov, input int op,
                            input bit eq, input bit clr, input bit rst);
    bit op_valid;
    int res;
    exp_t e;
`ifdef CALC_SUB_EN
    op_valid = (op == 0) || (op == 1);
`else
    op_valid = (op == 0);
`endif
    if (rst || clr) begin
      model_clear();
    end else if (mode == M_BUSY) begin
      busy_e++;
      if (busy_e == L) begin
        mode = M_SHOW; m_disp = pend_disp; m_neg = pend_neg;
      end
    end else if (eq) begin
      if (mode == M_OPB) begin
        if (m_sel == 1) begin
          res = (a_val >= b_val) ? a_val - b_val : b_val - a_val;
          pend_neg = (a_val < b_val);
        end else begin
          res = a_val + b_val;
          pend_neg = 1'b0;
        end
        pend_disp = fmt_result(res);
        e.disp = pend_disp; e.neg = pend_neg; e.cyc = cyc + L;
        exp_q.push_back(e);
        mode = M_BUSY; busy_e = 0;
      end
    end else if (ov) begin
      if (op_valid && mode == M_OPA) begin
        m_sel = op; mode = M_WAIT; m_disp = '1;
      end else if (op_valid && mode == M_WAIT) begin
        m_sel = op;
      end
    end else if (dv && d <= 9) begin
      case (mode)
        M_IDLE, M_SHOW: if (d != 0) begin
          a_val = d; a_len = 1; b_val = 0; b_len = 0; m_sel = 0; m_neg = 1'b0;
          mode = M_OPA; m_disp = fmt_entry(a_val, a_len);
        end
        M_OPA: if (a_len < N) begin
          a_val = a_val * 10 + d; a_len++; m_disp = fmt_entry(a_val, a_len);
        end
        M_WAIT: if (d != 0) begin
          b_val = d; b_len = 1; mode = M_OPB; m_disp = fmt_entry(b_val, b_len);
        end
        M_OPB: if (b_len < N) begin
          b_val = b_val * 10 + d; b_len++; m_disp = fmt_entry(b_val, b_len);
        end
        default: ;
      endcase
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit dv, input logic [3:0] d, input bit ov, input logic [1:0] op,
                      input bit eq, input bit clr, input bit rst);
    i_Digit_Valid = dv; i_Digit = d; i_Op_Valid = ov; i_Op = op;
    i_Equals = eq; i_Clear = clr; i_Reset = rst;
    @(posedge clk);
    #1;
    i_Digit_Valid = 1'b0; i_Op_Valid = 1'b0; i_Equals = 1'b0; i_Clear = 1'b0; i_Reset = 1'b0;
    model_step(dv, int'(d), ov, int'(op), eq, clr, rst);
    check("state",   o_State,    exp_state());
    check("display", o_Display,  m_disp);
    check("op_sel",  o_Op_Sel,   2'(m_sel));
    check("busy",    o_Busy,     mode == M_BUSY);
    check("negative", o_Negative, m_neg);
  endtask

  task automatic key(input logic [3:0] d);  step(1'b1, d, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); endtask
  task automatic opk(input logic [1:0] o);  step(1'b0, 4'd0, 1'b1, o, 1'b0, 1'b0, 1'b0); endtask
  task automatic eqk();                     step(1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0); endtask
  task automatic clrk();                    step(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0); endtask
  task automatic rstk();                    step(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- result monitor ----------------
  always @(negedge clk) begin
    if (o_Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", o_Done, 1'b0);
      end else begin
        check("done_display", o_Display, exp_q[0].disp);
        check("done_neg",     o_Negative, exp_q[0].neg);
        check("done_latency", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
      check("done_missing", o_Done, 1'b1);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    model_clear();
    rstk();
    rstk();
    check("rst_done",    o_Done,    1'b0);
    check("rst_display", o_Display, 12'hFFF);

    // 47 + 58
    key(4'd4); key(4'd7); opk(2'd0); key(4'd5); key(4'd8); eqk(); idle(L);
    check("plan_add_disp",  o_Display, 12'h105);
    check("plan_add_state", o_State,   3'd7);

    // 12 - 47
    clrk();
    key(4'd1); key(4'd2); opk(2'd1); key(4'd4); key(4'd7); eqk(); idle(L);
`ifdef CALC_SUB_EN
    check("plan_sub_disp", o_Display,  12'hF35);
    check("plan_sub_neg",  o_Negative, 1'b1);
`else
    check("plan_nosub_state", o_State,  3'd1);
    check("plan_nosub_opsel", o_Op_Sel, 2'd0);
`endif

    // digit saturation
    clrk();
    key(4'd1); key(4'd2); key(4'd3);
    check("sat_disp",  o_Display, 12'hF12);
    check("sat_state", o_State,   3'd1);

    // simultaneous digit and op: op wins
    step(1'b1, 4'd5, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    check("simul_state", o_State,   3'd2);
    check("simul_disp",  o_Display, 12'hFFF);
    key(4'd6); eqk(); idle(L);

    // blank-entry rules
    clrk();
    key(4'd0); key(4'd5); opk(2'd0); eqk(); key(4'd0); key(4'd3); eqk(); idle(L);
    check("blank_disp", o_Display, 12'hFF8);

    // abort mid-compute
    clrk();
    key(4'd9); key(4'd9); opk(2'd0); key(4'd9); key(4'd9); eqk(); idle(1); clrk();
    check("abort_state", o_State,   3'd0);
    check("abort_disp",  o_Display, 12'hFFF);
    idle(L + 2);

    // same sequence without abort
    key(4'd9); key(4'd9); opk(2'd0); key(4'd9); key(4'd9); eqk(); idle(L);
    check("max_disp", o_Display, 12'h198);

    // reset in OPB, then a fresh computation
    clrk();
    key(4'd1); opk(2'd0); key(4'd2); rstk();
    check("rstopb_state", o_State,   3'd0);
    check("rstopb_disp",  o_Display, 12'hFFF);
    check("rstopb_done",  o_Done,    1'b0);
    key(4'd3); opk(2'd0); key(4'd4); eqk(); idle(L);
    check("after_rst_disp", o_Display, 12'hFF7);

    // randomized keypresses
    for (int t = 0; t < 1500; t++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45)      key(4'($urandom_range(0, 9)));
      else if (r < 49) key(4'($urandom_range(10, 15)));
      else if (r < 61) opk(2'($urandom_range(0, 3)));
      else if (r < 73) eqk();
      else if (r < 75) clrk();
      else if (r < 76) rstk();
      else if (r < 81) step(1'b1, 4'($urandom_range(0, 9)), 1'b1, 2'($urandom_range(0, 3)),
                            1'($urandom_range(0, 1)), 1'b0, 1'b0);
      else             idle(1);
    end
    idle(L + 4);
    check("pending_results", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/calc_entry_core.md
# calc_entry_core

Parametrised calculator control core. It accepts debounced single-cycle key events, collects two BCD operands of up to NUM_DIGITS digits each, and computes an add (or optional subtract). The result is produced sequentially: BCD→binary, ALU, then binary→BCD via shift-add-3. It replaces the fixed two-digit, add-only entry FSM in the top level. Button debouncing and seven-segment decoding stay outside this block.

## Interface
- NUM_DIGITS, 2, max digits per operand (1..4)
- Derived: DISP_DIGITS = NUM_DIGITS+1
- Derived: RES_W = $clog2(2*10^NUM_DIGITS), binary result width (8 for NUM_DIGITS=2)
- i_Clk  in  1  system clock; all logic on rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_Digit_Valid  in  1  one-cycle pulse, digit key pressed
- i_Digit  in  4  digit value, sampled with i_Digit_Valid; values >9 ignored
- i_Op_Valid  in  1  one-cycle pulse, operation key pressed
- i_Op  in  2  00 add, 01 subtract, 10/11 ignored
- i_Equals  in  1  one-cycle pulse, execute
- i_Clear  in  1  one-cycle pulse, abort to IDLE
- o_Display  out  4*DISP_DIGITS  BCD nibbles, MS nibble first; 4'hF = blank
- o_Negative  out  1  result is negative (valid in SHOW)
- o_Op_Sel  out  2  latched operation, for indicator LEDs
- o_State  out  3  current state code
- o_Busy  out  1  high in CONV/ALU/B2D
- o_Done  out  1  one-cycle pulse when result is loaded into o_Display

## Operation
- State codes: IDLE 0, OPA 1, OPB_WAIT 2, OPB 3, CONV 4, ALU 5, B2D 6, SHOW 7.
- Event priority per cycle: i_Reset > i_Clear > i_Equals > i_Op_Valid > i_Digit_Valid. Only the highest event is acted on; the others are dropped.
- Digit handling:
  - A digit shifts into the active operand at the LS end.
  - A digit is ignored when the operand already holds NUM_DIGITS digits.
  - A 0 as the first digit of an operand is ignored (no leading zeros).
- IDLE:
  - Digit 1–9 loads A and goes to OPA.
  - Op and equals are ignored.
- OPA:
  - Digit appends to A.
  - Valid op latches o_Op_Sel and goes to OPB_WAIT.
  - Equals is ignored.
- OPB_WAIT:
  - Display is blank.
  - Digit 1–9 loads B and goes to OPB.
  - A new valid op replaces o_Op_Sel.
  - Equals is ignored.
- OPB:
  - Digit appends to B.
  - Equals goes to CONV.
  - Op is ignored.
- CONV:
  - A and B are converted in parallel, one digit per cycle (acc = acc*10 + digit), for NUM_DIGITS cycles, then ALU.
- ALU (1 cycle):
  - add: R = A+B.
  - sub: R = |A−B|, negative = (A<B).
- B2D:
  - Shift-add-3, one bit per cycle, RES_W cycles.
  - Then load o_Display, set o_Negative, pulse o_Done, and go to SHOW.
- SHOW:
  - Leading zeros are blanked; the LS nibble is always shown.
  - Digit 1–9 clears everything, loads A, and goes to OPA.
  - Op and equals are ignored.
- Entry display: the active operand right-aligned, unused nibbles 4'hF.
- Range: sum ≤ 2·(10^N−1) always fits DISP_DIGITS, so there is no overflow state.
- i_Clear from any state (including mid-compute):
  - Next state IDLE; operands zeroed; display all F; o_Negative 0; o_Op_Sel 00.
  - No o_Done is issued for an aborted computation.

## Timing
- Reset values: o_Display all 4'hF, o_Negative 0, o_Op_Sel 00, o_State 0, o_Busy 0, o_Done 0.
- All outputs are registered; an event at edge k is reflected in outputs after edge k.
- Execute latency: with i_Equals accepted at edge k, o_Busy is high from k+1, and o_Done pulses, o_Display updates, and o_Busy drops at edge k+L, where L = NUM_DIGITS + RES_W + 2 (12 for NUM_DIGITS=2).
- Events arriving while o_Busy is high are ignored, except reset and clear.
- o_Done is exactly one cycle wide.

## Configuration
- CALC_SUB_EN defined: op 01 is a valid subtract; o_Negative can be 1.
- CALC_SUB_EN undefined: op 01 is ignored like 10/11; no subtract/compare logic; o_Negative is tied 0.

## Test plan
- NUM_DIGITS=2: keys 4,7,+,5,8,= → o_Busy high 12 cycles → o_Done pulse, o_Display 0x105, o_Negative 0, o_State 7.
- CALC_SUB_EN on: 1,2,−,4,7,= → o_Display 0xF35, o_Negative 1.
- CALC_SUB_EN off: the same keys leave the core in OPA after "−"; o_Op_Sel stays 00.
- Digit saturation: 1,2,3 → o_Display 0xF12, state OPA.
- Simultaneous digit 5 and op: op wins, digit dropped.
- Blank-entry rules: 0,5,+,=,0,3,= → the first 0 is ignored; equals in OPB_WAIT is ignored; the leading 0 of B is ignored; result o_Display 0xFF8.
- Abort: 9,9,+,9,9,=, then i_Clear two cycles later → IDLE next cycle, display 0xFFF, no o_Done.
- Without the clear, the same sequence yields 0x198.
- i_Reset asserted in OPB → all outputs at reset values next cycle.
- After that reset, 3,+,4,= → 0xFF7.
